// File: rtl/logit_vector_collector_if.sv
// Stream-in / vector-out bundle between the NPU output layer and the bfloat16 max-find stage.
// The collector takes the slave view; the producer/consumer side takes the master view.
interface logit_vector_collector_if #(
    parameter int NUM_LOGITS = 10,
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 4
);
    logic                         s_valid;
    logic                         s_ready;
    logic [DATA_W-1:0]            s_data;
    logic                         s_last;
    logic                         vec_valid;
    logic                         vec_ready;
    logic [NUM_LOGITS*DATA_W-1:0] logits_flat;
    logic [CNT_W-1:0]             count;
    logic                         err_len;

    modport master (
        output s_valid, s_data, s_last, vec_ready,
        input  s_ready, vec_valid, logits_flat, count, err_len
    );

    modport slave (
        input  s_valid, s_data, s_last, vec_ready,
        output s_ready, vec_valid, logits_flat, count, err_len
    );
endinterface

// File: rtl/logit_vector_collector.sv
// Gathers NUM_LOGITS bfloat16 logits, one per beat, and holds them as a parallel vector until
// the max-find stage takes it. Optionally maps NaN to -inf and -0 to +0 so ties compare cleanly.
module logit_vector_collector #(
    parameter int NUM_LOGITS   = 10,
    parameter int DATA_W       = 16,
    parameter int CNT_W        = 4,
    parameter bit SANITIZE_NAN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    logit_vector_collector_if.slave  bus
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [DATA_W-1:0] NEG_INF  = 16'hFF80;
    localparam logic [DATA_W-1:0] NEG_ZERO = 16'h8000;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_LOGITS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NUM_LOGITS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic              wr_en;
    logic              accept;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] slot_q [NUM_LOGITS];

    function automatic logic [DATA_W-1:0] sanitize(input logic [DATA_W-1:0] d);
        if (SANITIZE_NAN) begin
            if (d[14:7] == 8'hFF && d[6:0] != 7'd0) return NEG_INF;
            if (d == NEG_ZERO)                      return '0;
        end
        return d;
    endfunction

    // A beat offered in the same cycle as flush is deliberately not taken.
    assign accept   = bus.s_valid && bus.s_ready && !flush;
    assign cap_data = sanitize(bus.s_data);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        if (flush) begin
            state_d = FILL;
            count_d = '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (accept) begin
                        if (count_q == LAST_IDX) begin
                            wr_en   = 1'b1;
                            state_d = HOLD;
                            count_d = FULL_CNT;
                            err_d   = !bus.s_last;
                        end else if (bus.s_last) begin
                            // Short vector: drop the beat and restart; stale slots are never shown.
                            err_d   = 1'b1;
                            count_d = '0;
                        end else begin
                            wr_en   = 1'b1;
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.vec_ready) begin
                        state_d = FILL;
                        count_d = '0;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the slot array is reset on purpose because logits_flat must read zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LOGITS; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LOGITS; i++) begin
                if (wr_en && count_q == CNT_W'(i)) slot_q[i] <= cap_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_LOGITS; g++) begin : g_flat
        assign bus.logits_flat[g*DATA_W +: DATA_W] = slot_q[g];
    end

    assign bus.s_ready   = (state_q == FILL);
    assign bus.vec_valid = (state_q == HOLD);
    assign bus.count     = count_q;
    assign bus.err_len   = err_q;

endmodule

// File: tb/tb_logit_vector_collector.sv
// Directed bench for logit_vector_collector: two instances (sanitizing and raw) share one stimulus.
module tb_logit_vector_collector;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] exp_v [N];
    logic [DW-1:0] san_v [N];

    always #5 clk = ~clk;

    logit_vector_collector_if #(.NUM_LOGITS(N), .DATA_W(DW), .CNT_W(CW)) bus0 ();
    logit_vector_collector_if #(.NUM_LOGITS(N), .DATA_W(DW), .CNT_W(CW)) bus1 ();

    assign bus1.s_valid   = bus0.s_valid;
    assign bus1.s_data    = bus0.s_data;
    assign bus1.s_last    = bus0.s_last;
    assign bus1.vec_ready = bus0.vec_ready;

    logit_vector_collector #(.NUM_LOGITS(N), .DATA_W(DW), .CNT_W(CW), .SANITIZE_NAN(1'b1)) dut_san (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus0)
    );

    logit_vector_collector #(.NUM_LOGITS(N), .DATA_W(DW), .CNT_W(CW), .SANITIZE_NAN(1'b0)) dut_raw (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus1)
    );

    function automatic logic [N*DW-1:0] pack(input logic [DW-1:0] v [N]);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = v[i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_exp(input logic [DW-1:0] base);
        for (int i = 0; i < N; i++) exp_v[i] = base + DW'(i);
    endtask

    // Streams exp_v back to back, s_last on the final beat only.
    task automatic send_exp();
        for (int i = 0; i < N; i++) begin
            bus0.s_valid = 1'b1;
            bus0.s_data  = exp_v[i];
            bus0.s_last  = (i == N - 1);
            step();
        end
        bus0.s_valid = 1'b0;
        bus0.s_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        flush   = 1'b0;
        bus0.s_valid   = 1'b0;
        bus0.s_data    = '0;
        bus0.s_last    = 1'b0;
        bus0.vec_ready = 1'b0;
        #12;
        total++; if (bus0.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus0.count); end
        total++; if (bus0.vec_valid !== 1'b0) begin bad++; $display("FAIL reset_vec_valid got=%b want=0", bus0.vec_valid); end
        total++; if (bus0.logits_flat !== '0) begin bad++; $display("FAIL reset_flat got=%h want=0", bus0.logits_flat); end
        total++; if (bus0.err_len !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus0.err_len); end
        reset_n = 1'b1;
        step();
        total++; if (bus0.s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b want=1", bus0.s_ready); end
    endtask

    task automatic test_basic();
        bus0.vec_ready = 1'b1;
        fill_exp(16'h3F80);
        send_exp();
        total++; if (bus0.vec_valid !== 1'b1) begin bad++; $display("FAIL basic_vec_valid got=%b want=1", bus0.vec_valid); end
        total++; if (bus0.count !== 4'd10) begin bad++; $display("FAIL basic_count got=%0d want=10", bus0.count); end
        total++; if (bus0.logits_flat[9*DW +: DW] !== 16'h3F89) begin bad++; $display("FAIL basic_slot9 got=%h want=3f89", bus0.logits_flat[9*DW +: DW]); end
        total++; if (bus0.logits_flat !== pack(exp_v)) begin bad++; $display("FAIL basic_flat got=%h want=%h", bus0.logits_flat, pack(exp_v)); end
        step();
        total++; if (bus0.vec_valid !== 1'b0 || bus0.s_ready !== 1'b1) begin bad++; $display("FAIL basic_refill got=%b%b want=01", bus0.vec_valid, bus0.s_ready); end
        total++; if (bus0.count !== 4'd0) begin bad++; $display("FAIL basic_count_clr got=%0d want=0", bus0.count); end
    endtask

    task automatic test_backpressure();
        bus0.vec_ready = 1'b0;
        fill_exp(16'h4000);
        send_exp();
        for (int k = 0; k < 5; k++) begin
            bus0.s_valid = 1'b1;
            bus0.s_data  = 16'hDEAD;
            bus0.s_last  = 1'b1;
            step();
            total++; if (bus0.vec_valid !== 1'b1 || bus0.s_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_%0d got=%b%b want=10", k, bus0.vec_valid, bus0.s_ready); end
            total++; if (bus0.logits_flat !== pack(exp_v)) begin bad++; $display("FAIL bp_flat_%0d got=%h want=%h", k, bus0.logits_flat, pack(exp_v)); end
            total++; if (bus0.count !== 4'd10) begin bad++; $display("FAIL bp_count_%0d got=%0d want=10", k, bus0.count); end
        end
        bus0.s_valid   = 1'b0;
        bus0.s_last    = 1'b0;
        bus0.vec_ready = 1'b1;
        step();
        total++; if (bus0.vec_valid !== 1'b0 || bus0.count !== 4'd0) begin bad++; $display("FAIL bp_release got=%b/%0d want=0/0", bus0.vec_valid, bus0.count); end
    endtask

    task automatic test_short_vector();
        // vec_ready left high: must be ignored while filling.
        for (int i = 0; i < 4; i++) begin
            bus0.s_valid = 1'b1;
            bus0.s_data  = 16'h5000 + 16'(i);
            bus0.s_last  = (i == 3);
            step();
            if (i == 2) begin
                total++; if (bus0.count !== 4'd3) begin bad++; $display("FAIL short_count3 got=%0d want=3", bus0.count); end
            end
        end
        bus0.s_valid = 1'b0;
        bus0.s_last  = 1'b0;
        total++; if (bus0.err_len !== 1'b1) begin bad++; $display("FAIL short_err got=%b want=1", bus0.err_len); end
        total++; if (bus0.count !== 4'd0 || bus0.vec_valid !== 1'b0) begin bad++; $display("FAIL short_state got=%0d/%b want=0/0", bus0.count, bus0.vec_valid); end
        step();
        total++; if (bus0.err_len !== 1'b0) begin bad++; $display("FAIL short_err_pulse got=%b want=0", bus0.err_len); end
        total++; if (bus0.vec_valid !== 1'b0) begin bad++; $display("FAIL short_no_vec got=%b want=0", bus0.vec_valid); end
        bus0.vec_ready = 1'b0;
        fill_exp(16'h4100);
        send_exp();
        total++; if (bus0.vec_valid !== 1'b1 || bus0.logits_flat !== pack(exp_v)) begin bad++; $display("FAIL short_next got=%b/%h want=1/%h", bus0.vec_valid, bus0.logits_flat, pack(exp_v)); end
        bus0.vec_ready = 1'b1;
        step();
    endtask

    task automatic test_sanitize();
        bus0.vec_ready = 1'b0;
        fill_exp(16'h3C00);
        exp_v[3] = 16'h7FC1;
        exp_v[5] = 16'h8000;
        exp_v[7] = 16'h7F80;
        exp_v[8] = 16'hFF81;
        san_v    = exp_v;
        san_v[3] = 16'hFF80;
        san_v[5] = 16'h0000;
        san_v[8] = 16'hFF80;
        send_exp();
        total++; if (bus0.logits_flat[3*DW +: DW] !== 16'hFF80) begin bad++; $display("FAIL san_nan got=%h want=ff80", bus0.logits_flat[3*DW +: DW]); end
        total++; if (bus0.logits_flat[5*DW +: DW] !== 16'h0000) begin bad++; $display("FAIL san_negzero got=%h want=0000", bus0.logits_flat[5*DW +: DW]); end
        total++; if (bus0.logits_flat !== pack(san_v)) begin bad++; $display("FAIL san_flat got=%h want=%h", bus0.logits_flat, pack(san_v)); end
        total++; if (bus1.logits_flat !== pack(exp_v)) begin bad++; $display("FAIL raw_flat got=%h want=%h", bus1.logits_flat, pack(exp_v)); end
        bus0.vec_ready = 1'b1;
        step();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) begin
            bus0.s_valid = 1'b1;
            bus0.s_data  = 16'h6000 + 16'(i);
            bus0.s_last  = 1'b0;
            step();
        end
        bus0.s_data = 16'h7777;
        flush       = 1'b1;
        step();
        flush        = 1'b0;
        bus0.s_valid = 1'b0;
        total++; if (bus0.count !== 4'd0 || bus0.vec_valid !== 1'b0 || bus0.s_ready !== 1'b1) begin bad++; $display("FAIL flush_fill got=%0d/%b/%b want=0/0/1", bus0.count, bus0.vec_valid, bus0.s_ready); end
        total++; if (bus0.err_len !== 1'b0) begin bad++; $display("FAIL flush_err got=%b want=0", bus0.err_len); end
        total++; if (bus0.logits_flat[0 +: DW] !== 16'h6000) begin bad++; $display("FAIL flush_keep got=%h want=6000", bus0.logits_flat[0 +: DW]); end
        total++; if (bus0.logits_flat[6*DW +: DW] !== 16'h3C06) begin bad++; $display("FAIL flush_beat_taken got=%h want=3c06", bus0.logits_flat[6*DW +: DW]); end
        bus0.vec_ready = 1'b0;
        fill_exp(16'h6100);
        send_exp();
        total++; if (bus0.vec_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_hold got=%b want=1", bus0.vec_valid); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (bus0.vec_valid !== 1'b0 || bus0.count !== 4'd0) begin bad++; $display("FAIL flush_hold got=%b/%0d want=0/0", bus0.vec_valid, bus0.count); end
        fill_exp(16'h6200);
        send_exp();
        total++; if (bus0.vec_valid !== 1'b1 || bus0.logits_flat !== pack(exp_v)) begin bad++; $display("FAIL flush_next got=%b/%h want=1/%h", bus0.vec_valid, bus0.logits_flat, pack(exp_v)); end
        bus0.vec_ready = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) begin
            bus0.s_valid = 1'b1;
            bus0.s_data  = 16'h7000 + 16'(i);
            bus0.s_last  = 1'b0;
            step();
        end
        bus0.s_data = 16'h7006;
        #3;
        reset_n = 1'b0;
        #1;
        total++; if (bus0.count !== 4'd0 || bus0.vec_valid !== 1'b0) begin bad++; $display("FAIL arst_state got=%0d/%b want=0/0", bus0.count, bus0.vec_valid); end
        total++; if (bus0.logits_flat !== '0 || bus0.err_len !== 1'b0) begin bad++; $display("FAIL arst_flat got=%h/%b want=0/0", bus0.logits_flat, bus0.err_len); end
        bus0.s_valid = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
        total++; if (bus0.s_ready !== 1'b1 || bus0.count !== 4'd0) begin bad++; $display("FAIL arst_release got=%b/%0d want=1/0", bus0.s_ready, bus0.count); end
        bus0.vec_ready = 1'b0;
        fill_exp(16'h7100);
        send_exp();
        total++; if (bus0.vec_valid !== 1'b1 || bus0.logits_flat !== pack(exp_v)) begin bad++; $display("FAIL arst_next got=%b/%h want=1/%h", bus0.vec_valid, bus0.logits_flat, pack(exp_v)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_short_vector();
        test_sanitize();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
